serial_frame_tx: RTL and testbench

//   Parallel-in, serial-out frame transmitter; the sending end of a serial link whose receiver
//   is a chain of D flip-flops sampling one line. Accepts a DATA_W-bit word on a LOAD/READY

---
 rtl/serial_frame_tx_pkg.sv | 25 ++
 rtl/serial_frame_tx_bit_timer.sv | 31 +++
 rtl/serial_frame_tx.sv | 120 ++++++++++++
 tb/tb_serial_frame_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame link: state encoding, frame length
// and counter-width helpers used by both the transmitter and the receiver.
package serial_frame_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_STOP_BITS = 1;
  localparam int FRAME_BITS    = 1 + DEF_DATA_W + DEF_STOP_BITS;

  function automatic int frame_bits(input int data_w, input int stop_bits);
    return 1 + data_w + stop_bits;
  endfunction

  // Counters are never narrower than one bit, even when a single count suffices.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while enabled and flags the
// last cycle of each bit period on o_tick.
module serial_frame_tx_bit_timer
  import serial_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits LSB
// first, STOP_BITS stop bits, each held CLKS_PER_BIT clocks on a high-idle line.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_load,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_txd,
  output logic              o_done,
  output logic [1:0]        o_dbg_state
);

  localparam int F  = frame_bits(DATA_W, STOP_BITS);
  localparam int BW = cnt_width(F);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  // Handshake: a word is taken on any rising edge where i_load and o_ready are
  // both high; o_ready stays low for the whole frame and loads are dropped.

  tx_state_e         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_txd;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_tick;
  logic              w_timer_en;
  logic [DATA_W-1:0] w_shifted;

  assign w_timer_en = (r_state != ST_IDLE);
  assign w_shifted  = r_shift >> 1;

  serial_frame_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_timer_en),
    .o_tick(w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_txd     <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_load && r_ready) begin
            r_shift   <= i_din;
            r_txd     <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_txd     <= r_shift[0];
            r_bit_cnt <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          // TXD already shows r_shift[0]; the next bit is the one after the shift.
          if (w_tick) begin
            if (r_bit_cnt == LAST_DATA) begin
              r_txd     <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= ST_STOP;
            end else begin
              r_txd     <= w_shifted[0];
              r_shift   <= w_shifted;
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_STOP) begin
              r_bit_cnt <= '0;
              r_ready   <= 1'b1;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_txd       = r_txd;
  assign o_ready     = r_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (C=4/1 stop and C=1/2 stop) checked
// every cycle against a timeline model, plus literal frame and latency checks.
module tb_serial_frame_tx;

  localparam int DW  = 8;
  localparam int C_A = 4;
  localparam int S_A = 1;
  localparam int C_B = 1;
  localparam int S_B = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    load;
  logic [DW-1:0] din [2];
  logic [1:0]    txd, ready, busy, done;
  logic [1:0]    st_a, st_b;
  logic          chk_en = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  logic [0:0] exp_q[$];

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(C_A), .STOP_BITS(S_A)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_din(din[0]), .i_load(load[0]),
    .o_ready(ready[0]), .o_busy(busy[0]), .o_txd(txd[0]), .o_done(done[0]),
    .o_dbg_state(st_a)
  );

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(C_B), .STOP_BITS(S_B)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_din(din[1]), .i_load(load[1]),
    .o_ready(ready[1]), .o_busy(busy[1]), .o_txd(txd[1]), .o_done(done[1]),
    .o_dbg_state(st_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Line level is a function of time since the accept edge: bit (t / C) of the frame.
  function automatic int c_of(input int d);
    return (d == 0) ? C_A : C_B;
  endfunction

  function automatic int f_of(input int d);
    return 1 + DW + ((d == 0) ? S_A : S_B);
  endfunction

  function automatic logic [15:0] build_frame(input logic [DW-1:0] data);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = data[i];
    return f;
  endfunction

  logic        m_busy [2];
  logic        m_done [2];
  int          m_t    [2];
  logic [15:0] m_fb   [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] <= 1'b0;
        m_done[d] <= 1'b0;
        m_t[d]    <= 0;
      end else if (m_busy[d]) begin
        if (m_t[d] + 1 == c_of(d) * f_of(d)) begin
          m_busy[d] <= 1'b0;
          m_done[d] <= 1'b1;
          m_t[d]    <= 0;
        end else begin
          m_t[d]    <= m_t[d] + 1;
          m_done[d] <= 1'b0;
        end
      end else begin
        m_done[d] <= 1'b0;
        if (load[d]) begin
          m_busy[d] <= 1'b1;
          m_t[d]    <= 0;
          m_fb[d]   <= build_frame(din[d]);
        end
      end
    end
  end

  logic exp_txd;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        exp_txd = m_busy[d] ? m_fb[d][m_t[d] / c_of(d)] : 1'b1;
        check($sformatf("model_txd_d%0d", d),   32'(txd[d]),   32'(exp_txd));
        check($sformatf("model_ready_d%0d", d), 32'(ready[d]), 32'(!m_busy[d]));
        check($sformatf("model_busy_d%0d", d),  32'(busy[d]),  32'(m_busy[d]));
        check($sformatf("model_done_d%0d", d),  32'(done[d]),  32'(m_done[d]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // lit holds the hand-written line sequence, bit 0 first on the wire.
  task automatic run_frame(input int d, input logic [DW-1:0] data, input logic [15:0] lit,
                           input int nbits, input int c, input int inj_j,
                           input logic [DW-1:0] inj_din);
    int j;
    int done_j;
    int extra;
    for (int b = 0; b < nbits; b++) exp_q.push_back(lit[b]);
    @(negedge clk);
    load[d] = 1'b1;
    din[d]  = data;
    @(negedge clk);
    load[d] = 1'b0;
    din[d]  = ~data;
    j = 0;
    done_j = -1;
    while (done_j < 0 && j < 400) begin
      if (j == inj_j) begin
        load[d] = 1'b1;
        din[d]  = inj_din;
      end else if (inj_j >= 0 && j == inj_j + 1) begin
        load[d] = 1'b0;
      end
      if ((j % c) == (c - 1) / 2 && (j / c) < nbits)
        check($sformatf("frame_bit%0d_d%0d", j / c, d), 32'(txd[d]), 32'(exp_q.pop_front()));
      if (done[d]) done_j = j;
      else begin
        @(negedge clk);
        j++;
      end
    end
    check($sformatf("done_latency_d%0d", d), done_j, c * nbits);
    check($sformatf("ready_at_done_d%0d", d), 32'(ready[d]), 32'd1);
    check($sformatf("txd_at_done_d%0d", d), 32'(txd[d]), 32'd1);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done[d]) extra++;
    end
    check($sformatf("extra_done_d%0d", d), extra, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int j;
    int d1;
    int d2;
    int ndone;
    logic [15:0] lit0;
    logic [15:0] lit1;

    rst     = 1'b1;
    load    = 2'b11;
    din[0]  = 8'hC3;
    din[1]  = 8'h3C;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_txd",   32'(txd[0]),   32'd1);
    check("rst_ready", 32'(ready[0]), 32'd1);
    check("rst_busy",  32'(busy[0]),  32'd0);
    check("rst_done",  32'(done[0]),  32'd0);
    check("rst_state", 32'(st_a),     32'd0);
    check("rst_txd_b", 32'(txd[1]),   32'd1);
    check("rst_state_b", 32'(st_b),   32'd0);
    rst  = 1'b0;
    load = 2'b00;
    repeat (3) @(negedge clk);
    check("idle_txd",   32'(txd[0]),   32'd1);
    check("idle_ready", 32'(ready[0]), 32'd1);

    // A5: 0,1,0,1,0,0,1,0,1,1
    run_frame(0, 8'hA5, 16'h034A, 10, C_A, -1, 8'h00);

    // 55 with a 3C load pulse ten cycles in
    run_frame(0, 8'h55, 16'h02AA, 10, C_A, 10, 8'h3C);

    // back-to-back: 00 then FF with LOAD held high
    lit0 = 16'h0200;
    lit1 = 16'h03FE;
    for (int b = 0; b < 10; b++) exp_q.push_back(lit0[b]);
    for (int b = 0; b < 10; b++) exp_q.push_back(lit1[b]);
    @(negedge clk);
    load[0] = 1'b1;
    din[0]  = 8'h00;
    @(negedge clk);
    din[0] = 8'hFF;
    j = 0; d1 = -1; d2 = -1; ndone = 0;
    while (j < 120) begin
      if (j == 41) load[0] = 1'b0;
      if (j == 40) check("b2b_gap_high", 32'(txd[0]), 32'd1);
      if (j == 41) check("b2b_second_start", 32'(txd[0]), 32'd0);
      if ((j < 40 && j % 4 == 1) || (j >= 41 && j < 81 && (j - 41) % 4 == 1))
        check($sformatf("b2b_bit_j%0d", j), 32'(txd[0]), 32'(exp_q.pop_front()));
      if (done[0]) begin
        ndone++;
        if (d1 < 0) d1 = j;
        else d2 = j;
      end
      @(negedge clk);
      j++;
    end
    check("b2b_done1", d1, 40);
    check("b2b_done2", d2, 81);
    check("b2b_done_count", ndone, 2);
    check("b2b_queue_empty", exp_q.size(), 0);

    // reset 17 cycles into an FF frame
    @(negedge clk);
    load[0] = 1'b1;
    din[0]  = 8'hFF;
    @(negedge clk);
    load[0] = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_txd",   32'(txd[0]),   32'd1);
    check("abort_ready", 32'(ready[0]), 32'd1);
    check("abort_busy",  32'(busy[0]),  32'd0);
    check("abort_done",  32'(done[0]),  32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (50) begin
      @(negedge clk);
      if (done[0]) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_frame(0, 8'hA5, 16'h034A, 10, C_A, -1, 8'h00);

    // C=1, two stop bits, 81: 0,1,0,0,0,0,0,0,1,1,1
    run_frame(1, 8'h81, 16'h0702, 11, C_B, -1, 8'h00);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
